// File: rtl/data_plane_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_plane_tx_pkg
// Description : Shared types and constants for the data-plane transmitter:
//               FSM state encoding, packet field widths, default message
//               length and the idle destination id.
// Revision    : 1.0 - initial release
// ============================================================================
package data_plane_tx_pkg;

  localparam int DEST_W = 16;
  localparam int DATA_W = 16;
  localparam int PKT_W  = DEST_W + DATA_W;

  localparam int                PKT_LEN_DEFAULT = 5;
  localparam logic [DEST_W-1:0] IDLE_ID_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } tx_state_t;

  // Packet driven whenever no message word is on the bus
  function automatic logic [PKT_W-1:0] idle_packet(input logic [DEST_W-1:0] idle_id);
    return {idle_id, {DATA_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_plane_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : Single-clock FIFO for the TX buffer. Pushes at full are
//               dropped even when a pop happens in the same cycle; pops at
//               empty are ignored. Head word is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_DEPTH = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage array: written on accepted pushes only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_plane_tx.sv
`default_nettype none
// ============================================================================
// Module      : data_plane_tx
// Description : Data-plane transmitter. The GPP fills a TX FIFO and requests
//               a send; once PKT_LEN words are buffered the block streams
//               {dest, word} packets on consecutive cycles, then drives the
//               idle packet with a one-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_plane_tx
  import data_plane_tx_pkg::*;
#(
  parameter int                PKT_LEN = PKT_LEN_DEFAULT,
  parameter int                DEPTH   = 16,
  parameter logic [DEST_W-1:0] IDLE_ID = IDLE_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpp_wr_en,
  input  logic [DATA_W-1:0] gpp_wr_data,
  input  logic              gpp_send,
  input  logic [DEST_W-1:0] dest_id,
  output logic [PKT_W-1:0]  data_tx_packet,
  output logic              data_tx_busy,
  output logic              data_tx_complete_flag,
  output logic              tx_buf_full,
  output logic              tx_buf_empty
);

  localparam int                c_CW       = $clog2(PKT_LEN + 1);
  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_CW-1:0]   c_LAST_IDX = c_CW'(PKT_LEN - 1);
  localparam logic [c_AW:0]     c_MIN_CNT  = (c_AW+1)'(PKT_LEN);

  tx_state_t          r_state;
  tx_state_t          w_next_state;
  logic [c_CW-1:0]    r_word_cnt;
  logic [DEST_W-1:0]  r_dest;
  logic [PKT_W-1:0]   r_packet;
  logic               r_complete;
  logic               r_busy;
  logic               w_start;
  logic               w_pop;
  logic               w_done;
  logic [DATA_W-1:0]  w_head;
  logic [c_AW:0]      w_count;

  tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gpp_wr_en),
    .din   (gpp_wr_data),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (tx_buf_full),
    .empty (tx_buf_empty),
    .count (w_count)
  );

  // A send is only honoured from IDLE with a full message buffered and a real node id
  assign w_start = (r_state == S_IDLE) && gpp_send && (w_count >= c_MIN_CNT)
                   && (dest_id != IDLE_ID);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_SEND;
      S_SEND:  if (r_word_cnt == c_LAST_IDX) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: pop a word every SEND cycle, finish in DONE
  always_comb begin
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_SEND:  w_pop  = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latched destination, word counter, packet and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest     <= IDLE_ID;
      r_word_cnt <= '0;
      r_packet   <= idle_packet(IDLE_ID);
      r_complete <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_complete <= w_done;
      r_busy     <= (w_next_state != S_IDLE);
      if (w_start) r_dest <= dest_id;
      if (w_pop) begin
        r_packet   <= {r_dest, w_head};
        r_word_cnt <= r_word_cnt + 1'b1;
      end else begin
        r_packet <= idle_packet(IDLE_ID);
        if (w_done) r_word_cnt <= '0;
      end
    end
  end

  assign data_tx_packet        = r_packet;
  assign data_tx_busy          = r_busy;
  assign data_tx_complete_flag = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_data_plane_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_plane_tx
// Description : Self-checking bench for data_plane_tx. A word queue models
//               the TX buffer; expected packets come from the message timing
//               rules (send edge, PKT_LEN data cycles, one idle+flag cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_plane_tx;

  localparam int          PKT_LEN = 5;
  localparam int          DEPTH   = 16;
  localparam logic [15:0] IDLE_ID = 16'hFFFF;
  localparam logic [31:0] IDLE_PKT = {16'hFFFF, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gpp_wr_en = 1'b0;
  logic [15:0] gpp_wr_data = '0;
  logic        gpp_send = 1'b0;
  logic [15:0] dest_id = '0;
  logic [31:0] data_tx_packet;
  logic        data_tx_busy;
  logic        data_tx_complete_flag;
  logic        tx_buf_full;
  logic        tx_buf_empty;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] mq[$];

  data_plane_tx #(.PKT_LEN(PKT_LEN), .DEPTH(DEPTH), .IDLE_ID(IDLE_ID)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .gpp_wr_en             (gpp_wr_en),
    .gpp_wr_data           (gpp_wr_data),
    .gpp_send              (gpp_send),
    .dest_id               (dest_id),
    .data_tx_packet        (data_tx_packet),
    .data_tx_busy          (data_tx_busy),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_buf_full           (tx_buf_full),
    .tx_buf_empty          (tx_buf_empty)
  );

  always #5 clk = ~clk;

  // One clock edge: update the buffer model (full check happens before the pop),
  // drive inputs, sample 1ns after the edge.
  task automatic cycle(input bit wr, input logic [15:0] d, input bit snd,
                       input logic [15:0] dst, input bit pop, output logic [15:0] popped);
    bit acc;
    acc = wr && (mq.size() < DEPTH);
    popped = 16'h0;
    if (pop && mq.size() > 0) popped = mq.pop_front();
    if (acc) mq.push_back(d);
    gpp_wr_en = wr; gpp_wr_data = d; gpp_send = snd; dest_id = dst;
    @(posedge clk);
    #1;
    gpp_wr_en = 1'b0; gpp_send = 1'b0;
  endtask

  task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_buffer(input string name);
    n_cmp++;
    if (tx_buf_empty !== (mq.size() == 0) || tx_buf_full !== (mq.size() == DEPTH)
        || dut.u_fifo.count !== 5'(mq.size())) begin
      n_err++;
      $display("FAIL %s: count=%0d empty=%b full=%b expected count=%0d", name,
               dut.u_fifo.count, tx_buf_empty, tx_buf_full, mq.size());
    end
  endtask

  task automatic write_words(input int n, input bit random_data, input logic [15:0] base);
    logic [15:0] w;
    for (int i = 0; i < n; i++)
      cycle(1'b1, random_data ? 16'($urandom) : base + 16'(i), 1'b0, 16'h0, 1'b0, w);
  endtask

  // Request a message and verify the whole response against the timing rules.
  task automatic send_msg(input logic [15:0] dst, input bit wr_during, input bit resend);
    bit ok;
    logic [15:0] w;
    ok = (mq.size() >= PKT_LEN) && (dst != IDLE_ID);
    cycle(1'b0, 16'h0, 1'b1, dst, 1'b0, w);
    if (!ok) begin
      cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, w);
      check_bits("ignored_send_busy", {31'h0, data_tx_busy}, 32'h0);
      check_bits("ignored_send_pkt", data_tx_packet, IDLE_PKT);
      return;
    end
    check_bits("start_busy", {31'h0, data_tx_busy}, 32'h1);
    check_bits("start_pkt", data_tx_packet, IDLE_PKT);
    for (int k = 0; k < PKT_LEN; k++) begin
      cycle(wr_during, 16'($urandom), resend, dst + 16'h1, 1'b1, w);
      check_bits("data_pkt", data_tx_packet, {dst, w});
      check_bits("data_flags", {30'h0, data_tx_busy, data_tx_complete_flag}, 32'h2);
    end
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, w);
    check_bits("done_pkt", data_tx_packet, IDLE_PKT);
    check_bits("done_flags", {30'h0, data_tx_busy, data_tx_complete_flag}, 32'h1);
    check_buffer("done_buffer");
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, w);
    check_bits("post_flag", {31'h0, data_tx_complete_flag}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; gpp_wr_en = 1'b1; gpp_wr_data = 16'hBEEF; gpp_send = 1'b1; dest_id = 16'h1;
    @(posedge clk); #1;
    rst = 1'b0; gpp_wr_en = 1'b0; gpp_send = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    check_bits("reset_pkt", data_tx_packet, IDLE_PKT);
    check_bits("reset_flags", {30'h0, data_tx_busy, data_tx_complete_flag}, 32'h0);
    check_buffer("reset_buffer");
  endtask

  task automatic test_basic();
    write_words(5, 1'b0, 16'h0011);
    check_buffer("basic_loaded");
    send_msg(16'h0003, 1'b0, 1'b0);
    check_bits("basic_empty", {31'h0, tx_buf_empty}, 32'h1);
  endtask

  task automatic test_short();
    write_words(4, 1'b1, 16'h0);
    send_msg(16'h0007, 1'b0, 1'b0);
    write_words(1, 1'b1, 16'h0);
    send_msg(16'h0007, 1'b0, 1'b0);
    write_words(5, 1'b1, 16'h0);
    send_msg(IDLE_ID, 1'b0, 1'b0);
    send_msg(16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    do_reset();
    write_words(15, 1'b1, 16'h0);
    check_bits("full_at_15", {31'h0, tx_buf_full}, 32'h0);
    write_words(1, 1'b1, 16'h0);
    check_bits("full_at_16", {31'h0, tx_buf_full}, 32'h1);
    write_words(1, 1'b1, 16'h0);
    check_buffer("full_drop");
    send_msg(16'h0009, 1'b0, 1'b0);
    send_msg(16'h000A, 1'b0, 1'b0);
    check_bits("full_count6", {27'h0, dut.u_fifo.count}, 32'd6);
    do_reset();
  endtask

  task automatic test_send_while_busy();
    write_words(5, 1'b1, 16'h0);
    send_msg(16'h0004, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    write_words(7, 1'b1, 16'h0);
    cycle(1'b0, 16'h0, 1'b1, 16'h0005, 1'b0, w);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, w);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, w);
    check_bits("mid_second_pkt", data_tx_packet, {16'h0005, w});
    do_reset();
    check_bits("mid_rst_pkt", data_tx_packet, IDLE_PKT);
    check_bits("mid_rst_flags", {30'h0, data_tx_busy, data_tx_complete_flag}, 32'h0);
    check_buffer("mid_rst_buffer");
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, w);
    check_bits("mid_no_pulse", {31'h0, data_tx_complete_flag}, 32'h0);
  endtask

  task automatic test_write_during_send();
    write_words(5, 1'b1, 16'h0);
    send_msg(16'h0006, 1'b1, 1'b0);
    check_bits("wds_count", {27'h0, dut.u_fifo.count}, 32'd5);
    send_msg(16'h0008, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      write_words(int'($urandom_range(0, 9)), 1'b1, 16'h0);
      send_msg(($urandom_range(0, 7) == 0) ? IDLE_ID : 16'($urandom_range(0, 16'hFFFE)),
               1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_full();
    test_send_while_busy();
    test_reset_mid();
    test_write_during_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/data_plane_tx.md
DATA_PLANE_TX -- requirements
Module: data_plane_tx

Interface
REQ-001 The block SHALL have parameter PKT_LEN, default 5, meaning data words per message (destination counts 0..4, so 5 words).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning TX buffer depth in 16-bit words (power of two).
REQ-003 The block SHALL have parameter IDLE_ID, default 16'hFFFF, meaning the destination field driven when no packet is sent; it matches no node.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- gpp_wr_en  in  1  GPP writes gpp_wr_data into the TX buffer
- gpp_wr_data  in  16  payload word
- gpp_send  in  1  GPP requests transmission of one message
- dest_id  in  16  destination node id, sampled with gpp_send
- data_tx_packet  out  32  {dest[31:16], data[15:0]} to the data plane
- data_tx_busy  out  1  message transmission in progress
- data_tx_complete_flag  out  1  one-cycle pulse at end of message
- tx_buf_full  out  1  buffer count == DEPTH
- tx_buf_empty  out  1  buffer count == 0

Function
REQ-006 The TX buffer SHALL be a FIFO; words leave in write order.
REQ-007 A write SHALL be accepted on a clock edge when gpp_wr_en=1 and count<DEPTH; writes at full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-008 Writes SHALL be accepted in every FSM state.
REQ-009 The FSM SHALL have three states: IDLE, SEND, DONE.
REQ-010 IDLE->SEND SHALL occur when gpp_send=1, count>=PKT_LEN and dest_id!=IDLE_ID; dest_id SHALL be latched on that edge. Otherwise gpp_send SHALL be ignored, with no pending request.
REQ-011 In SEND, each edge SHALL load data_tx_packet with {latched dest, FIFO head}, pop one word and increment a word counter (width clog2(PKT_LEN+1)).
REQ-012 After the PKT_LEN-th pop, SEND->DONE SHALL occur.
REQ-013 In DONE, one edge SHALL load data_tx_packet={IDLE_ID,16'h0000}, set data_tx_complete_flag=1, clear the word counter and go to IDLE.
REQ-014 data_tx_complete_flag SHALL be high for exactly one cycle per message.
REQ-015 Timing: with gpp_send accepted at edge N, packets SHALL be valid after edges N+1..N+PKT_LEN, and the idle packet plus complete flag after edge N+PKT_LEN+1, with no gaps.
REQ-016 data_tx_busy SHALL be 1 whenever state!=IDLE (registered).
REQ-017 gpp_send asserted while busy SHALL be ignored.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; count SHALL be clog2(DEPTH)+1 bits and update as +1 (write only), -1 (pop only), 0 (both or neither).
REQ-019 In IDLE, data_tx_packet SHALL hold {IDLE_ID,16'h0000}.

Reset
REQ-020 On rst=1 at an edge, the block SHALL set state=IDLE, empty the FIFO (pointers and count 0), clear the word counter, set latched dest=IDLE_ID, data_tx_packet={IDLE_ID,16'h0000}, data_tx_busy=0, data_tx_complete_flag=0, tx_buf_empty=1 and tx_buf_full=0.
REQ-021 Reset mid-message SHALL abort it with no complete pulse; remaining words SHALL be discarded.
REQ-022 Reset SHALL take priority over writes and gpp_send in the same cycle.

Structure
REQ-023 The shared package SHALL hold the FSM state enum (tx_state_t), PKT_LEN default, IDLE_ID and the packet field widths (DEST_W=16, DATA_W=16).
REQ-024 The FIFO SHALL be a sub-module tx_fifo (parameter DEPTH, WIDTH) with push, pop, dout, full, empty and count; the FSM, counter and packet register SHALL reside in data_plane_tx.

Verification
REQ-025 Write 16'h0011..16'h0015, send with dest 16'h0003 -> packets 32'h0003_0011..32'h0003_0015 on five consecutive cycles, then 32'hFFFF_0000 with complete=1 for one cycle, busy low, empty=1.
REQ-026 Write 4 words, pulse send -> no packet and busy stays 0; write a 5th word, send -> the message goes out normally.
REQ-027 Write 17 words -> full=1 after the 16th, 17th dropped; send twice -> two messages carrying words 1-5 and 6-10, count=6 after.
REQ-028 Assert send again during SEND with a different dest_id -> ignored, all packets keep the original dest, one complete pulse.
REQ-029 Assert rst after the 2nd packet -> next cycle packet=32'hFFFF_0000, busy=0, no complete pulse, empty=1.
REQ-030 Write one word per cycle during SEND with count=5 at start -> count at DONE equals the number of words written during SEND; write order is preserved in the next message.
